// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: banked PRF read-port arbiter, per-bank round-robin, registered port outputs.
// Define PRF_ARB_AGE_BOOST_EN to add per-requestor starvation counters with urgent-first scanning.
module prf_read_arbiter #(
  parameter int PRF_RR_COUNT = 11,
  parameter int PRF_BANK_COUNT = 4,
  parameter int PRF_READ_PORT_COUNT = 2,
  parameter int LOG_PR_COUNT = 7
`ifdef PRF_ARB_AGE_BOOST_EN
  ,
  parameter int STARVE_THRESHOLD = 7
`endif
  ,
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int UPW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT,
  localparam int RRW = $clog2(PRF_RR_COUNT),
  localparam int NP = PRF_BANK_COUNT * PRF_READ_PORT_COUNT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [PRF_RR_COUNT-1:0]     req_valid_by_rr,
  input  logic [PRF_RR_COUNT*LOG_PR_COUNT-1:0] req_PR_by_rr,
  output logic [PRF_RR_COUNT-1:0]     req_ready_by_rr,
  input  logic [NP-1:0]               port_disable_by_bank_by_port,
  output logic [NP-1:0]               read_valid_by_bank_by_port,
  output logic [NP*UPW-1:0]           read_upper_PR_by_bank_by_port,
  output logic [NP*RRW-1:0]           read_rr_by_bank_by_port
);

  logic [LOG_PR_COUNT-1:0] pr [PRF_RR_COUNT];
  logic [PRF_RR_COUNT-1:0] cand [PRF_BANK_COUNT];
  logic [RRW-1:0]          rr_ptr [PRF_BANK_COUNT];
  logic [RRW-1:0]          ptr_nxt [PRF_BANK_COUNT];
  logic [PRF_RR_COUNT-1:0] urgent;
  logic [PRF_RR_COUNT-1:0] grant_by_rr;
  logic [NP-1:0]           gnt_v;
  logic [RRW-1:0]          gnt_rr [NP];
  logic [UPW-1:0]          gnt_up [NP];

  always_comb begin
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      pr[i] = req_PR_by_rr[i*LOG_PR_COUNT +: LOG_PR_COUNT];
    end
  end

  always_comb begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        cand[b][i] = req_valid_by_rr[i] &&
          (pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

`ifdef PRF_ARB_AGE_BOOST_EN
  logic [2:0] starve [PRF_RR_COUNT];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) starve[i] <= '0;
    end else begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        if (!req_valid_by_rr[i] || req_ready_by_rr[i])
          starve[i] <= '0;
        else if (starve[i] != 3'd7)
          starve[i] <= starve[i] + 3'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      urgent[i] = int'(starve[i]) >= STARVE_THRESHOLD;
    end
  end
`else
  assign urgent = '0;
`endif

  // Pass 0 takes urgent candidates, pass 1 the rest; both walk from rr_ptr.
  always_comb begin
    int   idx;
    int   n;
    logic placed;
    idx = 0;
    n = 0;
    placed = 1'b0;
    gnt_v = '0;
    grant_by_rr = '0;
    for (int j = 0; j < NP; j++) begin
      gnt_rr[j] = '0;
      gnt_up[j] = '0;
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      ptr_nxt[b] = rr_ptr[b];
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < PRF_RR_COUNT; k++) begin
          idx = int'(rr_ptr[b]) + k;
          if (idx >= PRF_RR_COUNT) idx = idx - PRF_RR_COUNT;
          if (cand[b][idx] && (urgent[idx] == (pass == 0))) begin
            placed = 1'b0;
            for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
              n = b * PRF_READ_PORT_COUNT + p;
              if (!placed && !port_disable_by_bank_by_port[n] && !gnt_v[n]) begin
                gnt_v[n] = 1'b1;
                gnt_rr[n] = RRW'(idx);
                gnt_up[n] = pr[idx][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                placed = 1'b1;
              end
            end
            if (placed) begin
              grant_by_rr[idx] = 1'b1;
              ptr_nxt[b] = (idx == PRF_RR_COUNT - 1) ? '0 : RRW'(idx + 1);
            end
          end
        end
      end
    end
  end

  assign req_ready_by_rr = grant_by_rr & {PRF_RR_COUNT{~RST}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      read_valid_by_bank_by_port <= '0;
      read_upper_PR_by_bank_by_port <= '0;
      read_rr_by_bank_by_port <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) rr_ptr[b] <= '0;
    end else begin
      read_valid_by_bank_by_port <= gnt_v;
      for (int j = 0; j < NP; j++) begin
        read_upper_PR_by_bank_by_port[j*UPW +: UPW] <= gnt_up[j];
        read_rr_by_bank_by_port[j*RRW +: RRW] <= gnt_rr[j];
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) rr_ptr[b] <= ptr_nxt[b];
    end
  end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// tb_prf_read_arbiter: directed + random stimulus against a queue-based arbitration model.
// Honours PRF_ARB_AGE_BOOST_EN the same way as the design.
module tb_prf_read_arbiter;
  localparam int RR = 11;
  localparam int NB = 4;
  localparam int NPORT = 2;
  localparam int NP = NB * NPORT;
  localparam int UPW = 5;
  localparam int RRW = 4;
  localparam int STH = 7;

  logic CLK = 1'b0;
  logic RST;
  logic [RR-1:0] req_valid_by_rr;
  logic [RR*7-1:0] req_PR_by_rr;
  logic [RR-1:0] req_ready_by_rr;
  logic [NP-1:0] port_disable_by_bank_by_port;
  logic [NP-1:0] read_valid_by_bank_by_port;
  logic [NP*UPW-1:0] read_upper_PR_by_bank_by_port;
  logic [NP*RRW-1:0] read_rr_by_bank_by_port;

  prf_read_arbiter dut (
    .CLK(CLK),
    .RST(RST),
    .req_valid_by_rr(req_valid_by_rr),
    .req_PR_by_rr(req_PR_by_rr),
    .req_ready_by_rr(req_ready_by_rr),
    .port_disable_by_bank_by_port(port_disable_by_bank_by_port),
    .read_valid_by_bank_by_port(read_valid_by_bank_by_port),
    .read_upper_PR_by_bank_by_port(read_upper_PR_by_bank_by_port),
    .read_rr_by_bank_by_port(read_rr_by_bank_by_port)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  logic [RR-1:0] rv;
  logic [6:0] rpr [RR];
  logic [NP-1:0] dis;
  int ptr [NB];
  int n_ptr [NB];
  int st [RR];
  logic [RR-1:0] e_ready;
  logic [NP-1:0] e_v;
  logic [NP*UPW-1:0] e_up;
  logic [NP*RRW-1:0] e_rr;
  logic [RR-1:0] ready_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_urgent(int i);
`ifdef PRF_ARB_AGE_BOOST_EN
    return st[i] >= STH;
`else
    return st[i] < 0;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int i = 0; i < RR; i++) st[i] = 0;
  endtask

  task automatic model_eval();
    int order[$];
    int en[$];
    int i;
    int n;
    e_ready = '0;
    e_v = '0;
    e_up = '0;
    e_rr = '0;
    for (int b = 0; b < NB; b++) begin
      order.delete();
      en.delete();
      n_ptr[b] = ptr[b];
      for (int p = 0; p < NPORT; p++)
        if (!dis[b*NPORT+p]) en.push_back(p);
      for (int pass = 0; pass < 2; pass++)
        for (int k = 0; k < RR; k++) begin
          i = (ptr[b] + k) % RR;
          if (rv[i] && (int'(rpr[i]) % NB == b) && (is_urgent(i) == (pass == 0)))
            order.push_back(i);
        end
      for (int w = 0; w < en.size() && w < order.size(); w++) begin
        n = b * NPORT + en[w];
        i = order[w];
        e_ready[i] = 1'b1;
        e_v[n] = 1'b1;
        e_up[n*UPW +: UPW] = UPW'(int'(rpr[i]) / NB);
        e_rr[n*RRW +: RRW] = RRW'(i);
        n_ptr[b] = (i + 1) % RR;
      end
    end
  endtask

  task automatic pack();
    req_valid_by_rr = rv;
    for (int i = 0; i < RR; i++) req_PR_by_rr[i*7 +: 7] = rpr[i];
    port_disable_by_bank_by_port = dis;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step();
    pack();
    #3;
    model_eval();
    ready_seen = req_ready_by_rr;
    chk("ready", req_ready_by_rr, e_ready);
    @(posedge CLK);
    #1;
    for (int b = 0; b < NB; b++) ptr[b] = n_ptr[b];
    for (int i = 0; i < RR; i++)
      st[i] = (!rv[i] || e_ready[i]) ? 0 : ((st[i] < 7) ? st[i] + 1 : 7);
    chk("rd_valid", read_valid_by_bank_by_port, e_v);
    chk("rd_upper", read_upper_PR_by_bank_by_port, e_up);
    chk("rd_rr", read_rr_by_bank_by_port, e_rr);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    chk("rst_valid", read_valid_by_bank_by_port, '0);
    chk("rst_ready", req_ready_by_rr, '0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    rv = '0;
    dis = '0;
    for (int i = 0; i < RR; i++) rpr[i] = '0;
    pack();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valid", read_valid_by_bank_by_port, '0);
    chk("reset_upper", read_upper_PR_by_bank_by_port, '0);
    chk("reset_rr", read_rr_by_bank_by_port, '0);
    chk("reset_ready", req_ready_by_rr, '0);
    RST = 1'b0;

    rv[3] = 1'b1;
    rpr[3] = 7'h25;
    step();
    chk("t1_ready", ready_seen, 11'h008);
    chk("t1_valid", read_valid_by_bank_by_port, 8'h04);
    chk("t1_upper", read_upper_PR_by_bank_by_port[2*UPW +: UPW], 5'h09);
    chk("t1_rr", read_rr_by_bank_by_port[2*RRW +: RRW], 4'd3);

    rv = 11'h007;
    rpr[0] = 7'h10;
    rpr[1] = 7'h20;
    rpr[2] = 7'h04;
    step();
    chk("t2_c0", ready_seen, 11'h003);
    step();
    chk("t2_c1", ready_seen, 11'h005);
    step();
    chk("t2_c2", ready_seen, 11'h006);

    #2;
    RST = 1'b1;
    #1;
    chk("midrst_valid", read_valid_by_bank_by_port, '0);
    chk("midrst_rr", read_rr_by_bank_by_port, '0);
    chk("midrst_ready", req_ready_by_rr, '0);
    @(posedge CLK);
    #1;
    chk("rst_hold_valid", read_valid_by_bank_by_port, '0);
    RST = 1'b0;
    model_reset();
    step();
    chk("post_rst", ready_seen, 11'h003);
    do_reset();

    rv = '1;
    for (int i = 0; i < RR; i++) rpr[i] = 7'(i);
    step();
    chk("t3_ready", ready_seen, 11'h0FF);

    rv = '0;
    rv[2] = 1'b1;
    rv[6] = 1'b1;
    rpr[2] = 7'h02;
    rpr[6] = 7'h06;
    dis = 8'h10;
    step();
    chk("t4_ready", ready_seen, 11'h004);
    chk("t4_valid", read_valid_by_bank_by_port, 8'h20);
    chk("t4_rr", read_rr_by_bank_by_port[5*RRW +: RRW], 4'd2);

    do_reset();
    rv = '0;
    rv[0] = 1'b1;
    rv[1] = 1'b1;
    rv[9] = 1'b1;
    rpr[0] = 7'h00;
    rpr[1] = 7'h04;
    rpr[9] = 7'h08;
    dis = 8'h03;
    repeat (8) step();
    dis = '0;
    step();
`ifndef PRF_ARB_AGE_BOOST_EN
    chk("t5_ready", ready_seen, 11'h003);
`endif

    for (int it = 0; it < 1500; it++) begin
      for (int i = 0; i < RR; i++) begin
        if (!rv[i] || e_ready[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          rpr[i] = 7'($urandom_range(0, 127));
        end
      end
      for (int j = 0; j < NP; j++) dis[j] = ($urandom_range(0, 4) == 0);
      if (it == 700) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
